// File: rtl/linebuf_window_ctrl_if.sv
// Stream, line-buffer and column-output signals of the line-buffer window controller.
// The slave modport is the controller; the master modport is its environment.
interface linebuf_window_ctrl_if #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  logic                  lb0_ce;
  logic [AW-1:0]         lb0_addr;
  logic [DATA_WIDTH-1:0] lb0_din;
  logic [DATA_WIDTH-1:0] lb0_dout;

  logic                  lb1_ce;
  logic [AW-1:0]         lb1_addr;
  logic [DATA_WIDTH-1:0] lb1_din;
  logic [DATA_WIDTH-1:0] lb1_dout;

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_top;
  logic [DATA_WIDTH-1:0] m_mid;
  logic [DATA_WIDTH-1:0] m_bot;
  logic [AW-1:0]         m_col;
  logic [RW-1:0]         m_row;
  logic                  m_eof;
  logic                  busy;

  modport slave (
    input  s_valid, s_data, lb0_dout, lb1_dout,
    output s_ready, lb0_ce, lb0_addr, lb0_din, lb1_ce, lb1_addr, lb1_din,
           m_valid, m_top, m_mid, m_bot, m_col, m_row, m_eof, busy
  );

  modport master (
    output s_valid, s_data, lb0_dout, lb1_dout,
    input  s_ready, lb0_ce, lb0_addr, lb0_din, lb1_ce, lb1_addr, lb1_din,
           m_valid, m_top, m_mid, m_bot, m_col, m_row, m_eof, busy
  );
endinterface

// File: rtl/linebuf_window_ctrl.sv
// Sequences two cascaded read-before-write line buffers and emits a 3-tap
// vertical column per pixel of the previous row, with edge-row replication and a frame-end flush.
module linebuf_window_ctrl #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  linebuf_window_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [AW-1:0] COL_LAST = AW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  state_t        state;
  logic [AW-1:0] col;
  logic [RW-1:0] row;

  // Stage 0: issue logic (combinational)
  logic          flush_c, s_ready_c, accept_c, col_last_c, row_last_c;
  logic          out0_c, rep_top0_c, eof0_c;
  logic [RW-1:0] row0_c;

  assign flush_c    = (state == FLUSH);
  assign s_ready_c  = ~rst & ~flush_c;
  assign accept_c   = (bus.s_valid & s_ready_c) | flush_c;
  assign col_last_c = (col == COL_LAST);
  assign row_last_c = (row == ROW_LAST);
  assign out0_c     = (state == RUN) | flush_c;
  assign rep_top0_c = (state == RUN) & (row == RW'(1));
  assign eof0_c     = flush_c & col_last_c;
  assign row0_c     = flush_c ? ROW_LAST : RW'(row - RW'(1));

  // Frame sequencer and raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else if (accept_c) begin
      col <= col_last_c ? '0 : AW'(col + AW'(1));
      unique case (state)
        IDLE:  state <= PRIME;
        PRIME: if (col_last_c) begin
                 state <= RUN;
                 row   <= RW'(1);
               end
        RUN:   if (col_last_c) begin
                 if (row_last_c) state <= FLUSH;
                 else            row   <= RW'(row + RW'(1));
               end
        FLUSH: if (col_last_c) begin
                 state <= IDLE;
                 row   <= '0;
               end
      endcase
    end
  end

  // Stage 1 / stage 2 pipeline tags and data
  logic          s1_ce, s1_out, s1_rep_top, s1_rep_bot, s1_eof;
  logic [AW-1:0] s1_addr;
  logic [RW-1:0] s1_row;
  logic [DW-1:0] s1_bot;
  logic          s2_out, s2_rep_top, s2_rep_bot, s2_eof;
  logic [AW-1:0] s2_col;
  logic [RW-1:0] s2_row;
  logic [DW-1:0] s2_bot, s2_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ce      <= 1'b0;
      s1_out     <= 1'b0;
      s1_rep_top <= 1'b0;
      s1_rep_bot <= 1'b0;
      s1_eof     <= 1'b0;
      s1_addr    <= '0;
      s1_row     <= '0;
      s1_bot     <= '0;
      s2_out     <= 1'b0;
      s2_rep_top <= 1'b0;
      s2_rep_bot <= 1'b0;
      s2_eof     <= 1'b0;
      s2_col     <= '0;
      s2_row     <= '0;
      s2_bot     <= '0;
      s2_mid     <= '0;
    end else begin
      s1_ce      <= accept_c;
      s1_out     <= accept_c & out0_c;
      s1_rep_top <= rep_top0_c;
      s1_rep_bot <= flush_c;
      s1_eof     <= eof0_c;
      s1_addr    <= col;
      s1_row     <= row0_c;
      s1_bot     <= bus.s_data;
      s2_out     <= s1_out;
      s2_rep_top <= s1_rep_top;
      s2_rep_bot <= s1_rep_bot;
      s2_eof     <= s1_eof;
      s2_col     <= s1_addr;
      s2_row     <= s1_row;
      s2_bot     <= s1_bot;
      s2_mid     <= bus.lb0_dout;
    end
  end

  // Output column registers; border rows replicate the centre tap
  logic          m_valid_r, m_eof_r;
  logic [DW-1:0] m_top_r, m_mid_r, m_bot_r;
  logic [AW-1:0] m_col_r;
  logic [RW-1:0] m_row_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_eof_r   <= 1'b0;
      m_top_r   <= '0;
      m_mid_r   <= '0;
      m_bot_r   <= '0;
      m_col_r   <= '0;
      m_row_r   <= '0;
    end else begin
      m_valid_r <= s2_out;
      m_eof_r   <= s2_out & s2_eof;
      if (s2_out) begin
        m_top_r <= s2_rep_top ? s2_mid : bus.lb1_dout;
        m_mid_r <= s2_mid;
        m_bot_r <= s2_rep_bot ? s2_mid : s2_bot;
        m_col_r <= s2_col;
        m_row_r <= s2_row;
      end
    end
  end

  assign bus.s_ready  = s_ready_c;
  assign bus.lb0_ce   = accept_c;
  assign bus.lb0_addr = col;
  assign bus.lb0_din  = (accept_c & ~flush_c) ? bus.s_data : '0;
  assign bus.lb1_ce   = s1_ce;
  assign bus.lb1_addr = s1_addr;
  assign bus.lb1_din  = s1_ce ? bus.lb0_dout : '0;
  assign bus.m_valid  = m_valid_r;
  assign bus.m_top    = m_top_r;
  assign bus.m_mid    = m_mid_r;
  assign bus.m_bot    = m_bot_r;
  assign bus.m_col    = m_col_r;
  assign bus.m_row    = m_row_r;
  assign bus.m_eof    = m_eof_r;
  assign bus.busy     = (state != IDLE);
endmodule
